// File: rtl/kv_stream_fetcher.sv
// KV cache bank read fetcher: bursts a fetch command into bank reads, buffers in a FWFT FIFO.
// Define KV_FETCH_CKSUM_EN to add the cksum output (running XOR of pushed beats).
module kv_stream_fetcher #(
    parameter int MAX_LAYERS = 4,
    parameter int MAX_HEADS  = 4,
    parameter int MAX_SEQ    = 512,
    parameter int HEAD_DIM   = 16,
    parameter int DW         = 8,
    parameter int CHUNK      = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [$clog2(MAX_LAYERS)-1:0]  cmd_layer,
    input  logic [$clog2(MAX_HEADS)-1:0]   cmd_head,
    input  logic [$clog2(MAX_SEQ)-1:0]     cmd_time_start,
    input  logic [$clog2(MAX_SEQ):0]       cmd_len,
    input  logic                           cmd_is_v,
    output logic                           kv_req_valid,
    input  logic                           kv_req_ready,
    output logic [$clog2(MAX_LAYERS)-1:0]  kv_layer,
    output logic [$clog2(MAX_HEADS)-1:0]   kv_head,
    output logic                           kv_is_v,
    output logic [$clog2(MAX_SEQ)-1:0]     kv_time_start,
    output logic [$clog2(MAX_SEQ)-1:0]     kv_time_len,
    input  logic                           kv_data_valid,
    input  logic [HEAD_DIM*DW-1:0]         kv_data,
    input  logic                           kv_data_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [HEAD_DIM*DW-1:0]         out_data,
    output logic [$clog2(MAX_SEQ)-1:0]     out_time,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done,
    output logic                           err_cmd,
`ifdef KV_FETCH_CKSUM_EN
    output logic [HEAD_DIM*DW-1:0]         cksum,
`endif
    output logic                           err_proto
);
    localparam int TW   = $clog2(MAX_SEQ);
    localparam int NW   = TW + 1;
    localparam int XW   = NW + 1;
    localparam int DATW = HEAD_DIM * DW;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int EW   = DATW + TW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

    state_t                        state_q;
    logic [NW-1:0]                 rem_q, beat_q, blen;
    logic [TW-1:0]                 next_t_q, end_t_q, beat_t;
    logic [CW-1:0]                 cnt_q, free;
    logic [AW-1:0]                 wr_q, rd_q;
    logic [EW-1:0]                 mem_q [FIFO_DEPTH];
    logic [EW-1:0]                 head, entry;
    logic [$clog2(MAX_LAYERS)-1:0] layer_q;
    logic [$clog2(MAX_HEADS)-1:0]  head_q;
    logic                          is_v_q, done_q, err_cmd_q, err_proto_q;
    logic                          cmd_fire, cmd_bad, in_wait, beat_in;
    logic                          push, pop, full, last_beat, proto_bad;
    logic [XW-1:0]                 cmd_end;

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign cmd_end   = XW'(cmd_len) + XW'(cmd_time_start);
    assign cmd_bad   = (cmd_len == '0) || (cmd_end > XW'(MAX_SEQ));
    assign blen      = (rem_q > NW'(CHUNK)) ? NW'(CHUNK) : rem_q;
    assign free      = CW'(FIFO_DEPTH) - cnt_q;
    assign full      = (cnt_q == CW'(FIFO_DEPTH));
    assign in_wait   = (state_q == S_WAIT);
    assign beat_in   = kv_data_valid & in_wait;
    assign push      = beat_in & ~full;
    assign pop       = out_valid & out_ready;
    assign last_beat = ((beat_q + NW'(1)) == blen);
    assign beat_t    = next_t_q + TW'(beat_q);
    assign entry     = {kv_data, beat_t, beat_t == end_t_q};
    // Stray beats, misplaced last flags and overflow all count as violations.
    assign proto_bad = (kv_data_valid & ~in_wait)
                     | (beat_in & (full | (kv_data_last != last_beat)));

    assign cmd_ready     = (state_q == S_IDLE);
    assign busy          = ~cmd_ready;
    assign kv_req_valid  = (state_q == S_ISSUE) && (NW'(free) >= blen);
    assign kv_layer      = layer_q;
    assign kv_head       = head_q;
    assign kv_is_v       = is_v_q;
    assign kv_time_start = next_t_q;
    assign kv_time_len   = (state_q == S_ISSUE) ? TW'(blen - NW'(1)) : '0;
    assign done          = done_q;
    assign err_cmd       = err_cmd_q;
    assign err_proto     = err_proto_q;
    assign out_valid     = (cnt_q != '0);
    assign head          = out_valid ? mem_q[rd_q] : '0;
    assign {out_data, out_time, out_last} = head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            beat_q      <= '0;
            next_t_q    <= '0;
            end_t_q     <= '0;
            layer_q     <= '0;
            head_q      <= '0;
            is_v_q      <= 1'b0;
            done_q      <= 1'b0;
            err_cmd_q   <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            err_cmd_q   <= 1'b0;
            err_proto_q <= proto_bad;
            case (state_q)
                S_IDLE: if (cmd_valid) begin
                    layer_q <= cmd_layer;
                    head_q  <= cmd_head;
                    is_v_q  <= cmd_is_v;
                    if (cmd_bad) begin
                        done_q    <= 1'b1;
                        err_cmd_q <= 1'b1;
                    end else begin
                        rem_q    <= cmd_len;
                        next_t_q <= cmd_time_start;
                        end_t_q  <= cmd_time_start + TW'(cmd_len) - TW'(1);
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: if (kv_req_valid && kv_req_ready) begin
                    beat_q  <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: if (beat_in) begin
                    if (last_beat) begin
                        beat_q   <= '0;
                        rem_q    <= rem_q - blen;
                        next_t_q <= next_t_q + TW'(blen);
                        state_q  <= (rem_q == blen) ? S_DRAIN : S_ISSUE;
                    end else begin
                        beat_q <= beat_q + NW'(1);
                    end
                end
                S_DRAIN: if (cnt_q == '0) begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= entry;
    end

`ifdef KV_FETCH_CKSUM_EN
    logic [DATW-1:0] cksum_q;
    assign cksum = cksum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           cksum_q <= '0;
        else if (cmd_fire) cksum_q <= '0;
        else if (push)     cksum_q <= cksum_q ^ kv_data;
    end
`endif
endmodule

// File: tb/tb_kv_stream_fetcher.sv
// Directed bench for kv_stream_fetcher: bursting, backpressure, illegal
// commands, protocol errors, reset mid-burst and (optionally) the checksum.
module tb_kv_stream_fetcher;
    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready, cmd_is_v;
    logic [1:0]   cmd_layer, cmd_head;
    logic [8:0]   cmd_time_start;
    logic [9:0]   cmd_len;
    logic         kv_req_valid, kv_req_ready, kv_is_v;
    logic [1:0]   kv_layer, kv_head;
    logic [8:0]   kv_time_start, kv_time_len;
    logic         kv_data_valid, kv_data_last;
    logic [127:0] kv_data;
    logic         out_valid, out_ready, out_last;
    logic [127:0] out_data;
    logic [8:0]   out_time;
    logic         busy, done, err_cmd, err_proto;
`ifdef KV_FETCH_CKSUM_EN
    logic [127:0] cksum;
`endif

    int           n_cmp = 0;
    int           n_err = 0;
    bit           onehot = 1'b0;
    logic [127:0] exp_ck;

    always #5 clk = ~clk;

    kv_stream_fetcher dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_layer(cmd_layer), .cmd_head(cmd_head),
        .cmd_time_start(cmd_time_start), .cmd_len(cmd_len),
        .cmd_is_v(cmd_is_v),
        .kv_req_valid(kv_req_valid), .kv_req_ready(kv_req_ready),
        .kv_layer(kv_layer), .kv_head(kv_head), .kv_is_v(kv_is_v),
        .kv_time_start(kv_time_start), .kv_time_len(kv_time_len),
        .kv_data_valid(kv_data_valid), .kv_data(kv_data),
        .kv_data_last(kv_data_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_time(out_time), .out_last(out_last),
        .busy(busy), .done(done), .err_cmd(err_cmd),
`ifdef KV_FETCH_CKSUM_EN
        .cksum(cksum),
`endif
        .err_proto(err_proto)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] vec(input int t);
        logic [7:0] b;
        b = onehot ? 8'(1 << t) : (8'(t) ^ 8'hA5);
        return {16{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input int l, input int h, input int s,
                            input int n, input bit v);
        cmd_valid      = 1'b1;
        cmd_layer      = 2'(l);
        cmd_head       = 2'(h);
        cmd_time_start = 9'(s);
        cmd_len        = 10'(n);
        cmd_is_v       = v;
        exp_ck         = '0;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic serve_burst(input int s, input int b, input int bad);
        int n;
        n = 0;
        while (!kv_req_valid && n < 40) begin
            tick();
            n++;
        end
        chk("req_valid", kv_req_valid, 1);
        chk("req_start", kv_time_start, s);
        chk("req_len", kv_time_len, b - 1);
        kv_req_ready = 1'b1;
        tick();
        kv_req_ready = 1'b0;
        for (int i = 0; i < b; i++) begin
            kv_data_valid = 1'b1;
            kv_data       = vec(s + i);
            kv_data_last  = (i == bad);
            exp_ck        = exp_ck ^ vec(s + i);
            tick();
            chk("beat_err", err_proto, 128'((i == bad) != (i == b - 1)));
        end
        kv_data_valid = 1'b0;
        kv_data_last  = 1'b0;
    endtask

    task automatic serve_cmd(input int s, input int n);
        int t;
        int r;
        int b;
        t = s;
        r = n;
        while (r > 0) begin
            b = (r < 8) ? r : 8;
            serve_burst(t, b, b - 1);
            t += b;
            r -= b;
        end
    endtask

    task automatic collect(input int s, input int n, input int last_t);
        int w;
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (!out_valid && w < 200) begin
                tick();
                w++;
            end
            chk("out_valid", out_valid, 1);
            chk("out_time", out_time, s + k);
            chk("out_data", out_data, vec(s + k));
            chk("out_last", out_last, 128'(s + k == last_t));
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic check_done();
        chk("done_early", done, 0);
        tick();
        chk("done", done, 1);
        chk("done_errcmd", err_cmd, 0);
        chk("done_busy", busy, 0);
`ifdef KV_FETCH_CKSUM_EN
        chk("cksum", cksum, exp_ck);
`endif
        tick();
        chk("done_pulse", done, 0);
    endtask

    initial begin
        rst            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_layer      = '0;
        cmd_head       = '0;
        cmd_time_start = '0;
        cmd_len        = '0;
        cmd_is_v       = 1'b0;
        kv_req_ready   = 1'b0;
        kv_data_valid  = 1'b0;
        kv_data        = '0;
        kv_data_last   = 1'b0;
        out_ready      = 1'b0;
        exp_ck         = '0;
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_req", kv_req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_done", done, 0);
        chk("rst_errs", {err_cmd, err_proto}, 0);
        chk("rst_kv_len", kv_time_len, 0);
        rst = 1'b0;
        tick();

        send_cmd(1, 2, 10, 3, 1'b0);
        chk("t1_busy", busy, 1);
        chk("t1_fields", {kv_layer, kv_head, kv_is_v}, {2'd1, 2'd2, 1'b0});
        serve_cmd(10, 3);
        collect(10, 3, 12);
        check_done();

        send_cmd(0, 1, 10, 20, 1'b1);
        chk("t2_is_v", kv_is_v, 1);
        out_ready = 1'b1;
        fork
            serve_cmd(10, 20);
            collect(10, 20, 29);
        join
        check_done();

        send_cmd(3, 3, 10, 20, 1'b0);
        serve_burst(10, 8, 7);
        serve_burst(18, 8, 7);
        chk("bp_hold0", kv_req_valid, 0);
        tick();
        tick();
        tick();
        chk("bp_hold1", kv_req_valid, 0);
        chk("bp_head", out_time, 10);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_free1", kv_req_valid, 0);
        chk("bp_head2", out_time, 11);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        chk("bp_free4", kv_req_valid, 1);
        serve_burst(26, 4, 3);
        collect(14, 16, 29);
        check_done();

        send_cmd(0, 0, 500, 13, 1'b0);
        chk("ill_done", done, 1);
        chk("ill_err", err_cmd, 1);
        chk("ill_req", kv_req_valid, 0);
        chk("ill_ready", cmd_ready, 1);
`ifdef KV_FETCH_CKSUM_EN
        chk("ill_cksum", cksum, 0);
`endif
        tick();
        chk("ill_pulse", {done, err_cmd, kv_req_valid}, 0);
        send_cmd(0, 0, 5, 0, 1'b0);
        chk("len0_done", {done, err_cmd}, 2'b11);
        chk("len0_req", kv_req_valid, 0);
        tick();
        chk("len0_pulse", {done, err_cmd, busy}, 0);

        send_cmd(2, 1, 500, 12, 1'b1);
        chk("edge_busy", busy, 1);
        serve_cmd(500, 12);
        collect(500, 12, 511);
        check_done();

        send_cmd(0, 0, 40, 3, 1'b0);
        serve_burst(40, 3, 1);
        collect(40, 3, 42);
        check_done();

        kv_data_valid = 1'b1;
        kv_data       = vec(7);
        tick();
        kv_data_valid = 1'b0;
        chk("idle_err", err_proto, 1);
        chk("idle_drop", out_valid, 0);
        tick();
        chk("idle_pulse", err_proto, 0);

        onehot = 1'b1;
        send_cmd(0, 0, 0, 3, 1'b0);
        serve_cmd(0, 3);
        collect(0, 3, 2);
        check_done();
        chk("ck_model", exp_ck, {16{8'h07}});
        onehot = 1'b0;

        send_cmd(1, 1, 0, 8, 1'b0);
        kv_req_ready = 1'b1;
        tick();
        kv_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            kv_data_valid = 1'b1;
            kv_data       = vec(i);
            tick();
        end
        kv_data_valid = 1'b0;
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #2;
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out", {out_valid, out_data}, 0);
        chk("mid_rst_req", kv_req_valid, 0);
        chk("mid_rst_fields", {kv_layer, kv_head, kv_time_start}, 0);
        tick();
        rst = 1'b0;
        kv_data_valid = 1'b1;
        tick();
        kv_data_valid = 1'b0;
        chk("post_rst_err", err_proto, 1);
        chk("post_rst_drop", out_valid, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
